// File: rtl/instr_ram_pkg.sv
// instr_ram_pkg
// Shared definitions for the instruction-RAM Wishbone bridge: the Wishbone
// slave FSM state type, bus widths and the default Wishbone base address of
// the instruction RAM window.
package instr_ram_pkg;

    localparam int          WB_DW             = 32;
    localparam int          WB_SELW           = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

    // Wishbone slave side: idle, waiting for RAM read data, acknowledging
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } wb_state_t;

endpackage

// File: rtl/instr_ram_arb.sv
// instr_ram_arb
// Two-requester arbiter for the single RAM port. The core fetch port has
// priority, but a pending Wishbone access that keeps losing is granted once it
// has lost STARVE_MAX consecutive cycles. Grants are combinational and forced
// low while reset is asserted.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_wbReq        : in-window Wishbone request pending
//   i_coreReq      : core fetch request
//   o_wbGnt        : Wishbone wins the RAM this cycle
//   o_coreGnt      : core wins the RAM this cycle
module instr_ram_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_wbReq,
    input  logic i_coreReq,
    output logic o_wbGnt,
    output logic o_coreGnt
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] r_waitCnt;
    logic       w_wbWins;

    // Wishbone wins when alone, or once it has been starved long enough
    assign w_wbWins  = i_wbReq & (~i_coreReq | (r_waitCnt >= STARVE_LIM));
    assign o_wbGnt   = ~i_rst & w_wbWins;
    assign o_coreGnt = ~i_rst & i_coreReq & ~w_wbWins;

    // Count consecutive Wishbone losses; any win or idle cycle starts over.
    // Saturates so a long-stalled request cannot wrap back to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_waitCnt <= '0;
        end else if (!i_wbReq || w_wbWins) begin
            r_waitCnt <= '0;
        end else if (r_waitCnt < STARVE_LIM) begin
            r_waitCnt <= r_waitCnt + 8'd1;
        end
    end

endmodule

// File: rtl/instr_ram_wb_bridge.sv
// instr_ram_wb_bridge
// Shares one single-port instruction SRAM macro between the Caravel Wishbone
// slave port and the rvj1 core fetch port. Wishbone accesses are byte-masked
// and classic (one outstanding access); core fetches are pipelined, one per
// cycle, with up to RAM_LATENCY in flight.
// Ports:
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   wbs_*                       : Wishbone classic slave
//   core_req_i/core_addr_i      : fetch request and word address
//   core_gnt_o                  : fetch accepted this cycle (combinational)
//   core_rvalid_o/core_rdata_o  : fetch data, RAM_LATENCY cycles after grant
//   ram_*                       : SRAM macro controls (csb/web active-low)
//   err_o                       : sticky out-of-window access flag
module instr_ram_wb_bridge
    import instr_ram_pkg::*;
#(
    parameter int          RAM_AW      = 10,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          RAM_LATENCY = 1,
    parameter int          STARVE_MAX  = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [WB_SELW-1:0] wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [WB_DW-1:0]   wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [WB_DW-1:0]   wbs_dat_o,
    input  logic               core_req_i,
    input  logic [RAM_AW-1:0]  core_addr_i,
    output logic               core_gnt_o,
    output logic               core_rvalid_o,
    output logic [WB_DW-1:0]   core_rdata_o,
    output logic               ram_csb_o,
    output logic               ram_web_o,
    output logic [WB_SELW-1:0] ram_wmask_o,
    output logic [RAM_AW-1:0]  ram_addr_o,
    output logic [WB_DW-1:0]   ram_din_o,
    input  logic [WB_DW-1:0]   ram_dout_i,
    output logic               err_o
);

    // 33-bit window bounds so a window ending at 4 GiB does not wrap
    localparam logic [32:0] WIN_LO       = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI       = WIN_LO + (33'd4 << RAM_AW);
    localparam logic [1:0]  RD_WAIT_INIT = 2'(RAM_LATENCY - 1);

    wb_state_t               r_state;
    logic [1:0]              r_rdCnt;
    logic                    r_ack;
    logic [WB_DW-1:0]        r_dat;
    logic                    r_err;
    logic [RAM_LATENCY-1:0]  r_coreValid;

    logic                    w_wbReq;
    logic                    w_inWindow;
    logic                    w_wbGnt;
    logic                    w_coreGnt;
    logic [RAM_AW-1:0]       w_wbWordAddr;

    assign w_wbReq      = wbs_cyc_i & wbs_stb_i & (r_state == IDLE);
    assign w_inWindow   = ({1'b0, wbs_adr_i} >= WIN_LO) && ({1'b0, wbs_adr_i} < WIN_HI);
    assign w_wbWordAddr = wbs_adr_i[RAM_AW+1:2];

    instr_ram_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_wbReq   (w_wbReq & w_inWindow),
        .i_coreReq (core_req_i),
        .o_wbGnt   (w_wbGnt),
        .o_coreGnt (w_coreGnt)
    );

    // The arbitration winner drives the macro directly in its grant cycle;
    // with no winner the macro sees a fully idle, zeroed interface.
    always_comb begin
        ram_csb_o   = 1'b1;
        ram_web_o   = 1'b1;
        ram_wmask_o = '0;
        ram_addr_o  = '0;
        ram_din_o   = '0;
        if (w_wbGnt) begin
            ram_csb_o  = 1'b0;
            ram_web_o  = ~wbs_we_i;
            ram_addr_o = w_wbWordAddr;
            if (wbs_we_i) begin
                ram_wmask_o = wbs_sel_i;
                ram_din_o   = wbs_dat_i;
            end
        end else if (w_coreGnt) begin
            ram_csb_o  = 1'b0;
            ram_addr_o = core_addr_i;
        end
    end

    // Wishbone slave FSM. Out-of-window accesses never touch the RAM and are
    // acknowledged with zero data. Reads wait RAM_LATENCY cycles, then
    // register the macro output. A master that drops cyc during the read
    // wait abandons the access: the RAM still completes it but no ack is sent.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_rdCnt <= '0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wbReq) begin
                        if (!w_inWindow) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                            r_dat   <= '0;
                            r_err   <= 1'b1;
                        end else if (w_wbGnt) begin
                            if (wbs_we_i) begin
                                r_state <= ACK;
                                r_ack   <= 1'b1;
                                r_dat   <= '0;
                            end else begin
                                r_state <= RD_WAIT;
                                r_rdCnt <= RD_WAIT_INIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (!wbs_cyc_i) begin
                        r_state <= IDLE;
                    end else if (r_rdCnt == 2'd0) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        r_dat   <= ram_dout_i;
                    end else begin
                        r_rdCnt <= r_rdCnt - 2'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_dat   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    // One bit per pipeline stage of the macro; bit RAM_LATENCY-1 lines up
    // with the cycle the macro presents data for that fetch.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_coreValid <= '0;
        end else begin
            r_coreValid[0] <= w_coreGnt;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_coreValid[i] <= r_coreValid[i-1];
            end
        end
    end

    assign wbs_ack_o     = r_ack;
    assign wbs_dat_o     = r_dat;
    assign err_o         = r_err;
    assign core_gnt_o    = w_coreGnt;
    assign core_rvalid_o = r_coreValid[RAM_LATENCY-1];
    assign core_rdata_o  = core_rvalid_o ? ram_dout_i : '0;

endmodule

// File: tb/tb_instr_ram_wb_bridge.sv
// tb_instr_ram_wb_bridge
// Directed bench for instr_ram_wb_bridge. Two bridges are built: "A" with a
// one-cycle RAM and "B" with a two-cycle RAM, each backed by its own SRAM
// model preloaded with a recognisable pattern (A: A000_0000|word,
// B: B000_0000|word).
module tb_instr_ram_wb_bridge;

    logic clk = 1'b0;
    logic rstA, rstB, memInit;

    logic        aCyc, aStb, aWe, aAck, aCoreReq, aGnt, aRvalid, aCsb, aWeb, aErr;
    logic [3:0]  aSel, aMask;
    logic [31:0] aAdr, aDat, aDatO, aRdata, aDin, aDout;
    logic [9:0]  aCoreAddr, aRamAddr;

    logic        bCyc, bStb, bWe, bAck, bCoreReq, bGnt, bRvalid, bCsb, bWeb, bErr;
    logic [3:0]  bSel, bMask;
    logic [31:0] bAdr, bDat, bDatO, bRdata, bDin, bDout, bStage;
    logic [9:0]  bCoreAddr, bRamAddr;

    logic [31:0] memA [1024];
    logic [31:0] memB [1024];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_ram_wb_bridge #(
        .RAM_AW(10), .BASE_ADDR(32'h3000_0000), .RAM_LATENCY(1), .STARVE_MAX(4)
    ) dutA (
        .wb_clk_i(clk), .wb_rst_i(rstA),
        .wbs_cyc_i(aCyc), .wbs_stb_i(aStb), .wbs_we_i(aWe), .wbs_sel_i(aSel),
        .wbs_adr_i(aAdr), .wbs_dat_i(aDat), .wbs_ack_o(aAck), .wbs_dat_o(aDatO),
        .core_req_i(aCoreReq), .core_addr_i(aCoreAddr), .core_gnt_o(aGnt),
        .core_rvalid_o(aRvalid), .core_rdata_o(aRdata),
        .ram_csb_o(aCsb), .ram_web_o(aWeb), .ram_wmask_o(aMask), .ram_addr_o(aRamAddr),
        .ram_din_o(aDin), .ram_dout_i(aDout), .err_o(aErr)
    );

    instr_ram_wb_bridge #(
        .RAM_AW(10), .BASE_ADDR(32'h3000_0000), .RAM_LATENCY(2), .STARVE_MAX(4)
    ) dutB (
        .wb_clk_i(clk), .wb_rst_i(rstB),
        .wbs_cyc_i(bCyc), .wbs_stb_i(bStb), .wbs_we_i(bWe), .wbs_sel_i(bSel),
        .wbs_adr_i(bAdr), .wbs_dat_i(bDat), .wbs_ack_o(bAck), .wbs_dat_o(bDatO),
        .core_req_i(bCoreReq), .core_addr_i(bCoreAddr), .core_gnt_o(bGnt),
        .core_rvalid_o(bRvalid), .core_rdata_o(bRdata),
        .ram_csb_o(bCsb), .ram_web_o(bWeb), .ram_wmask_o(bMask), .ram_addr_o(bRamAddr),
        .ram_din_o(bDin), .ram_dout_i(bDout), .err_o(bErr)
    );

    // One-cycle SRAM model with byte-masked writes
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 1024; i++) memA[i] <= 32'hA000_0000 | 32'(i);
        end else if (!aCsb) begin
            if (!aWeb) begin
                for (int b = 0; b < 4; b++)
                    if (aMask[b]) memA[aRamAddr][8*b +: 8] <= aDin[8*b +: 8];
            end else begin
                aDout <= memA[aRamAddr];
            end
        end
    end

    // Two-cycle SRAM model: read data passes through an extra register
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 1024; i++) memB[i] <= 32'hB000_0000 | 32'(i);
        end else if (!bCsb) begin
            if (!bWeb) begin
                for (int b = 0; b < 4; b++)
                    if (bMask[b]) memB[bRamAddr][8*b +: 8] <= bDin[8*b +: 8];
            end else begin
                bStage <= memB[bRamAddr];
            end
        end
        bDout <= bStage;
    end

    // Watchdog so a broken design can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one bridge's inputs, then let combinational outputs settle
    task automatic applyStimulus(input bit toB, input logic cyc, input logic we,
                                 input logic [3:0] sel, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic coreReq,
                                 input logic [9:0] coreAddr);
        if (!toB) begin
            aCyc = cyc; aStb = cyc; aWe = we; aSel = sel; aAdr = adr; aDat = dat;
            aCoreReq = coreReq; aCoreAddr = coreAddr;
        end else begin
            bCyc = cyc; bStb = cyc; bWe = we; bSel = sel; bAdr = adr; bDat = dat;
            bCoreReq = coreReq; bCoreAddr = coreAddr;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Uncontended Wishbone write on bridge A: ack exactly one cycle after grant
    task automatic wbWriteA(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input string tag);
        applyStimulus(0, 1, 1, sel, adr, dat, 0, 0);
        checkOutput({tag, "_csb"}, 32'(aCsb), 32'd0);
        tick();
        checkOutput({tag, "_ack"}, 32'(aAck), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    // Uncontended Wishbone read on bridge A: ack two cycles after grant
    task automatic wbReadA(input logic [31:0] adr, input logic [31:0] expData,
                           input string tag);
        applyStimulus(0, 1, 0, 4'hF, adr, 0, 0, 0);
        tick();
        checkOutput({tag, "_ack_early"}, 32'(aAck), 32'd0);
        tick();
        checkOutput({tag, "_ack"}, 32'(aAck), 32'd1);
        checkOutput({tag, "_data"}, aDatO, expData);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        // ---------------- reset, core request held high on A ----------------
        rstA = 1'b1; rstB = 1'b1; memInit = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 10'd7);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_gnt_forced", 32'(aGnt), 32'd0);
        checkOutput("rst_csb", 32'(aCsb), 32'd1);
        checkOutput("rst_web", 32'(aWeb), 32'd1);
        checkOutput("rst_mask", 32'(aMask), 32'd0);
        checkOutput("rst_addr", 32'(aRamAddr), 32'd0);
        checkOutput("rst_din", aDin, 32'd0);
        checkOutput("rst_ack", 32'(aAck), 32'd0);
        checkOutput("rst_dat", aDatO, 32'd0);
        checkOutput("rst_rvalid", 32'(aRvalid), 32'd0);
        checkOutput("rst_rdata", aRdata, 32'd0);
        checkOutput("rst_err", 32'(aErr), 32'd0);
        checkOutput("rstB_ack", 32'(bAck), 32'd0);
        rstA = 1'b0; rstB = 1'b0; memInit = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // ---------------- full-word write then read back ----------------
        applyStimulus(0, 1, 1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 0, 0);
        checkOutput("wr_csb", 32'(aCsb), 32'd0);
        checkOutput("wr_web", 32'(aWeb), 32'd0);
        checkOutput("wr_mask", 32'(aMask), 32'hF);
        checkOutput("wr_addr", 32'(aRamAddr), 32'd4);
        checkOutput("wr_din", aDin, 32'hDEAD_BEEF);
        tick();
        checkOutput("wr_ack_t1", 32'(aAck), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("wr_ack_drop", 32'(aAck), 32'd0);

        applyStimulus(0, 1, 0, 4'hF, 32'h3000_0010, 32'h0, 0, 0);
        checkOutput("rd_web", 32'(aWeb), 32'd1);
        checkOutput("rd_mask", 32'(aMask), 32'd0);
        tick();
        checkOutput("rd_ack_t1", 32'(aAck), 32'd0);
        tick();
        checkOutput("rd_ack_t2", 32'(aAck), 32'd1);
        checkOutput("rd_data", aDatO, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // ---------------- byte-masked write ----------------
        wbWriteA(32'h3000_0020, 32'h1122_3344, 4'hF, "mw_full");
        wbWriteA(32'h3000_0020, 32'h0000_00AB, 4'h1, "mw_byte");
        wbReadA(32'h3000_0020, 32'h1122_33AB, "mw_read");

        // ---------------- starvation: core streams, one WB read ----------------
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, (k < 6), 0, 4'hF, 32'h3000_0010, 0, 1, 10'(16 + k));
            if (k < 4) begin
                checkOutput($sformatf("starve_core_gnt%0d", k), 32'(aGnt), 32'd1);
                checkOutput($sformatf("starve_core_addr%0d", k), 32'(aRamAddr), 32'(16 + k));
            end
            if (k == 1) checkOutput("starve_rdata1", aRdata, 32'hA000_0010);
            if (k == 4) begin
                checkOutput("starve_wb_win_gnt", 32'(aGnt), 32'd0);
                checkOutput("starve_wb_addr", 32'(aRamAddr), 32'd4);
                checkOutput("starve_wb_web", 32'(aWeb), 32'd1);
            end
            if (k == 5) begin
                checkOutput("starve_gnt_after", 32'(aGnt), 32'd1);
                checkOutput("starve_rvalid_gap", 32'(aRvalid), 32'd0);
                checkOutput("starve_ack_early", 32'(aAck), 32'd0);
            end
            if (k == 6) begin
                checkOutput("starve_ack", 32'(aAck), 32'd1);
                checkOutput("starve_data", aDatO, 32'hDEAD_BEEF);
                checkOutput("starve_rdata5", aRdata, 32'hA000_0015);
            end
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // ---------------- out-of-window accesses and window edge ----------------
        applyStimulus(0, 1, 0, 4'hF, 32'h3000_1000, 0, 0, 0);
        checkOutput("oow_csb", 32'(aCsb), 32'd1);
        tick();
        checkOutput("oow_ack", 32'(aAck), 32'd1);
        checkOutput("oow_data", aDatO, 32'd0);
        checkOutput("oow_err", 32'(aErr), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("oow_ack_drop", 32'(aAck), 32'd0);
        applyStimulus(0, 1, 1, 4'hF, 32'h2FFF_FFFC, 32'h5555_5555, 0, 0);
        checkOutput("oow_low_csb", 32'(aCsb), 32'd1);
        tick();
        checkOutput("oow_low_ack", 32'(aAck), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 0, 4'hF, 32'h3000_0FFC, 0, 0, 0);
        checkOutput("edge_addr", 32'(aRamAddr), 32'h3FF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        wbReadA(32'h3000_0FFC, 32'hA000_03FF, "edge_read");
        checkOutput("err_sticky", 32'(aErr), 32'd1);

        // ---------------- bridge B: back-to-back fetches, latency 2 ----------------
        for (int c = 0; c < 11; c++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, (c < 8), 10'(c));
            if (c < 8) checkOutput($sformatf("b_gnt%0d", c), 32'(bGnt), 32'd1);
            checkOutput($sformatf("b_rvalid%0d", c), 32'(bRvalid),
                        32'((c >= 2) && (c < 10)));
            if (c >= 2 && c < 10)
                checkOutput($sformatf("b_rdata%0d", c), bRdata, 32'hB000_0000 | 32'(c - 2));
            tick();
        end

        // bridge B Wishbone read: ack three cycles after grant
        applyStimulus(1, 1, 0, 4'hF, 32'h3000_0008, 0, 0, 0);
        tick();
        checkOutput("b_rd_t1", 32'(bAck), 32'd0);
        tick();
        checkOutput("b_rd_t2", 32'(bAck), 32'd0);
        tick();
        checkOutput("b_rd_t3", 32'(bAck), 32'd1);
        checkOutput("b_rd_data", bDatO, 32'hB000_0002);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // ---------------- bridge B: reset during WB read and core fetch ----------------
        applyStimulus(1, 1, 0, 4'hF, 32'h3000_000C, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 4'hF, 32'h3000_000C, 0, 1, 10'd5);
        checkOutput("brst_gnt_pre", 32'(bGnt), 32'd1);
        tick();
        rstB = 1'b1;
        applyStimulus(1, 1, 0, 4'hF, 32'h3000_000C, 0, 1, 10'd6);
        checkOutput("brst_gnt_forced", 32'(bGnt), 32'd0);
        checkOutput("brst_csb", 32'(bCsb), 32'd1);
        tick();
        rstB = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("brst_ack", 32'(bAck), 32'd0);
        checkOutput("brst_rvalid", 32'(bRvalid), 32'd0);
        checkOutput("brst_rdata", bRdata, 32'd0);
        checkOutput("brst_dat", bDatO, 32'd0);
        checkOutput("brst_err", 32'(bErr), 32'd0);
        tick();
        checkOutput("brst_ack_late", 32'(bAck), 32'd0);
        checkOutput("brst_rvalid_late", 32'(bRvalid), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_ram_wb_bridge.md
# instr_ram_wb_bridge

Parametrised bridge that shares one single-port instruction SRAM macro between the Caravel management Wishbone slave port and the rvj1 core's instruction-fetch port. Provides byte-masked Wishbone writes, pipelined core fetches, configurable RAM read latency and a starvation-bounded arbiter so firmware can load or patch instruction memory while the core runs. Sits in `user_project_wrapper` between the Wishbone slave interface, the core fetch unit and the SRAM macro.

## Interface
- `RAM_AW`, 10, RAM word-address width (depth = 2^RAM_AW 32-bit words)
- `BASE_ADDR`, 32'h3000_0000, Wishbone byte address of word 0
- `RAM_LATENCY`, 1, macro read latency in cycles (legal: 1, 2)
- `STARVE_MAX`, 4, consecutive cycles a pending WB access may lose to the core (legal: 1..255)
- `wb_clk_i` in 1: sole clock; RAM macro clocked by the same clock
- `wb_rst_i` in 1: reset, synchronous, active-high
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic cycle, strobe, write-enable
- `wbs_sel_i` in 4: byte selects
- `wbs_adr_i` in 32: byte address
- `wbs_dat_i` in 32: write data
- `wbs_ack_o` out 1: one-cycle acknowledge
- `wbs_dat_o` out 32: read data, valid with ack
- `core_req_i` in 1: fetch request
- `core_addr_i` in RAM_AW: fetch word address
- `core_gnt_o` out 1: request accepted this cycle
- `core_rvalid_o` out 1: fetch data valid
- `core_rdata_o` out 32: fetch data
- `ram_csb_o`, `ram_web_o` out 1 each: macro chip-select / write-enable, active-low
- `ram_wmask_o` out 4, `ram_addr_o` out RAM_AW, `ram_din_o` out 32: macro controls/data
- `ram_dout_i` in 32: macro read data
- `err_o` out 1: sticky, set by any out-of-window WB access

## Operation
- WB request = `wbs_cyc_i & wbs_stb_i` while WB FSM in IDLE. In-window: `BASE_ADDR <= adr < BASE_ADDR + 4*2^RAM_AW`; RAM word = `adr[RAM_AW+1:2]`.
- Out-of-window: no RAM access; ack next cycle, `wbs_dat_o`=0, write dropped, `err_o` set until reset.
- Arbiter, per cycle, one RAM access max: only one requester -> it wins. Both -> core wins while `wait_cnt < STARVE_MAX`, else WB wins. `wait_cnt` increments each cycle an in-window WB request loses; clears when WB wins or no WB request pending; saturates at STARVE_MAX.
- Winner drives macro: `ram_csb_o`=0, `ram_web_o`=~we (core always read), `ram_wmask_o`=`wbs_sel_i` for WB write, 0 for reads. No winner: csb=1, web=1, mask=0, addr=0, din=0.
- WB FSM: IDLE -> (granted write) ACK; IDLE -> (granted read) RD_WAIT -> (after RAM_LATENCY cycles) ACK; IDLE -> (out-of-window) ACK; ACK -> IDLE. Request is not re-sampled in ACK; next request accepted no earlier than the cycle after ack.
- Core path pipelined: `core_gnt_o` combinational in the grant cycle; one fetch per cycle; up to RAM_LATENCY fetches in flight, tracked by a valid shift register. `core_rdata_o` = `ram_dout_i` when `core_rvalid_o`, else 0.
- `wbs_cyc_i` dropped while in RD_WAIT: access completes in RAM, ack suppressed, FSM returns to IDLE.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `core_gnt_o`=0, `core_rvalid_o`=0, `core_rdata_o`=0, `err_o`=0, macro outputs idle (csb=1, web=1, mask/addr/din=0), FSM IDLE, `wait_cnt`=0.
- Reset asserted mid-operation: in-flight WB and core reads discarded; no ack/rvalid after reset; `core_gnt_o` forced 0 during reset.
- WB write granted at cycle T: `wbs_ack_o` at T+1.
- WB read granted at T: `wbs_dat_o` registered from `ram_dout_i`, ack at T+RAM_LATENCY+1.
- Core fetch granted at T: `core_rvalid_o` at T+RAM_LATENCY.
- Worst-case WB grant delay under continuous core requests: STARVE_MAX cycles.

## Structure
- Package `instr_ram_pkg`: WB FSM state enum (IDLE, RD_WAIT, ACK), `WB_DW`=32, `WB_SELW`=4, default `BASE_ADDR`.
- Sub-module `instr_ram_arb`: two-requester arbiter with `wait_cnt` starvation counter; grant outputs only. Top holds WB FSM, window decode, read pipeline and macro muxing.

## Test plan
- WB write 0xDEADBEEF, sel=4'hF to 0x3000_0010, then read: ack one cycle after grant, read returns 0xDEADBEEF, ack at T+2 (RAM_LATENCY=1).
- Byte-masked write 0x0000_00AB, sel=4'h1 over 0x1122_3344 -> read 0x1122_33AB.
- Core fetches words 0..7 back-to-back -> gnt every cycle, rvalid stream with data matching preload, RAM_LATENCY=2 gives first rvalid two cycles after first gnt.
- Continuous core requests plus one WB read, STARVE_MAX=4 -> core wins 4 cycles, WB granted on 5th, `core_gnt_o`=0 that cycle.
- WB read at 0x3000_1000 (RAM_AW=10, out of window) -> ack next cycle, data 0, `err_o`=1 and sticky.
- Reset pulsed during WB RD_WAIT and two core fetches in flight -> no ack, no rvalid, all outputs at reset values the cycle after reset.
